chip8_delay_sound_timers: RTL

- Holds the CHIP-8 delay timer (DT) and sound timer (ST) registers.
- Consumes the single-cycle 60 Hz tick from the tick generator and decrements both registers at 60 Hz.
- Accepts loads from the CPU (FX15, FX18) and exposes DT for FX07.
- Drives the sound-active flag and the beeper pin for the board top level.

---
 rtl/chip8_delay_sound_timers.sv | 106 ++++++++++
 1 files changed

// File: rtl/chip8_delay_sound_timers.sv
// CHIP-8 delay (DT) and sound (ST) timers.
// Both registers count down on the 60 Hz tick and saturate at zero.
// The CPU loads them through dt_we/st_we (FX15/FX18) and reads DT back (FX07).
// A load always beats a coincident tick, and only that register loses the tick.
// freeze drops ticks; they are not queued.
// Build option: define CHIP8_BEEP_TONE_EN to make beep_out a square wave at
// TONE_HZ while ST != 0, for a passive speaker. Without it, beep_out simply
// follows sound_active, which suits an active buzzer.
module chip8_delay_sound_timers #(
    parameter int unsigned CLOCK_HZ = 12000000,
    parameter int unsigned TONE_HZ  = 440
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       timer_60hz_tick,
    input  logic       freeze,
    input  logic       dt_we,
    input  logic       st_we,
    input  logic [7:0] wdata,
    output logic [7:0] dt_value,
    output logic [7:0] st_value,
    output logic       sound_active,
    output logic       beep_out
);

    localparam int unsigned TIMER_W = 8;

    // Zero-valued parameters would make the tone period meaningless.
    if (CLOCK_HZ == 0 || TONE_HZ == 0) begin : g_bad_cfg
        $error("chip8_delay_sound_timers: CLOCK_HZ and TONE_HZ must be non-zero");
    end

    logic [TIMER_W-1:0] r_dt;
    logic [TIMER_W-1:0] r_st;
    logic [TIMER_W-1:0] w_dt_next;
    logic [TIMER_W-1:0] w_st_next;
    logic               w_tick_live;

    // A tick only counts when the timers are not frozen.
    assign w_tick_live = timer_60hz_tick & ~freeze;

    // Next-value selection for both timers: load, else saturating decrement, else hold.
    always_comb begin
        w_dt_next = r_dt;
        w_st_next = r_st;

        if (dt_we) begin
            w_dt_next = wdata;
        end else if (w_tick_live && (r_dt != '0)) begin
            w_dt_next = r_dt - TIMER_W'(1);
        end

        if (st_we) begin
            w_st_next = wdata;
        end else if (w_tick_live && (r_st != '0)) begin
            w_st_next = r_st - TIMER_W'(1);
        end
    end

    // Timer registers; reset clears both immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dt <= '0;
            r_st <= '0;
        end else begin
            r_dt <= w_dt_next;
            r_st <= w_st_next;
        end
    end

    assign dt_value     = r_dt;
    assign st_value     = r_st;
    assign sound_active = (r_st != '0);

`ifdef CHIP8_BEEP_TONE_EN
    localparam int unsigned HALF_RAW = CLOCK_HZ / (2 * TONE_HZ);
    localparam int unsigned HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
    localparam int unsigned CNT_W    = 32;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

    logic [CNT_W-1:0] r_tone_cnt;
    logic             r_beep;

    // Half-period counter and square-wave output; idles low when silent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tone_cnt <= '0;
            r_beep     <= 1'b0;
        end else if (!sound_active) begin
            r_tone_cnt <= '0;
            r_beep     <= 1'b0;
        end else if (r_tone_cnt == CNT_LAST) begin
            r_tone_cnt <= '0;
            r_beep     <= ~r_beep;
        end else begin
            r_tone_cnt <= r_tone_cnt + CNT_W'(1);
        end
    end

    assign beep_out = r_beep;
`else
    // Active buzzer: drive it straight from the sound flag.
    assign beep_out = sound_active;
`endif

endmodule
